fetch_stage_v: RTL

- Instruction-fetch stage placed directly upstream of the 1024x32 synchronous instruction ROM (`rom_v`).
- Owns the PC and drives the ROM word address.
- Absorbs the ROM's 1-cycle read latency and presents an IF/ID register {pc, instr, valid} to decode.
- Handles decode stalls through a one-entry skid buffer, and handles branch/jump redirects with flush.

---
 rtl/fetch_stage_v.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage_v.sv
// fetch_stage_v: instruction-fetch stage in front of the 1024x32 synchronous ROM.
// Owns the PC, absorbs the ROM's 1-cycle read latency, and holds one instruction
// in a skid buffer while decode stalls. Redirects flush everything and refetch.
// Optional build macro FETCH_MISALIGN_CHK_EN adds misalign_o / misalign_pc_o.
module fetch_stage_v #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ADDR_W   = 10,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_instr,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_instr,
    output logic              id_valid
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic              misalign_o,
    output logic [XLEN-1:0]   misalign_pc_o
`endif
);

    localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight_v;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_instr;
    logic            r_skid_v;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_instr;
    logic            r_id_valid;

    // Redirect target with the two byte-offset bits forced to zero
    logic [XLEN-1:0] w_redirect_pc;
    assign w_redirect_pc = redirect_pc_i & ~LOW_MASK;

    // ROM word address comes straight off the PC register
    assign rom_addr = r_fetch_pc[ADDR_W+1:2];
    assign id_pc    = r_id_pc;
    assign id_instr = r_id_instr;
    assign id_valid = r_id_valid;

    // Fetch FSM: PC sequencing, in-flight tracking, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight_v  <= 1'b0;
            r_skid_pc     <= '0;
            r_skid_instr  <= NOP;
            r_skid_v      <= 1'b0;
            r_id_pc       <= '0;
            r_id_instr    <= NOP;
            r_id_valid    <= 1'b0;
        end else if (redirect_i) begin
            // Flush: drop in-flight and skid, restart fetch at the target
            r_state      <= S_FILL;
            r_fetch_pc   <= w_redirect_pc;
            r_inflight_v <= 1'b0;
            r_skid_v     <= 1'b0;
            r_id_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    // First read issued; its data returns next cycle
                    r_inflight_pc <= r_fetch_pc;
                    r_inflight_v  <= 1'b1;
                    r_fetch_pc    <= r_fetch_pc + PC_STEP;
                    r_state       <= S_RUN;
                end
                S_RUN: begin
                    if (stall_i) begin
                        // Park the returning word; keep re-reading fetch_pc
                        r_skid_pc     <= r_inflight_pc;
                        r_skid_instr  <= rom_instr;
                        r_skid_v      <= r_inflight_v;
                        r_inflight_pc <= r_fetch_pc;
                        r_state       <= S_HOLD;
                    end else begin
                        r_id_pc       <= r_inflight_pc;
                        r_id_instr    <= rom_instr;
                        r_id_valid    <= r_inflight_v;
                        r_inflight_pc <= r_fetch_pc;
                        r_fetch_pc    <= r_fetch_pc + PC_STEP;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        // Drain skid into IF/ID; the re-read word is already in flight
                        r_id_pc       <= r_skid_pc;
                        r_id_instr    <= r_skid_instr;
                        r_id_valid    <= r_skid_v;
                        r_skid_v      <= 1'b0;
                        r_inflight_pc <= r_fetch_pc;
                        r_fetch_pc    <= r_fetch_pc + PC_STEP;
                        r_state       <= S_RUN;
                    end
                end
                default: begin
                    r_state      <= S_FILL;
                    r_inflight_v <= 1'b0;
                    r_skid_v     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_pc;

    assign misalign_o    = r_misalign;
    assign misalign_pc_o = r_misalign_pc;

    // One-cycle flag and sticky raw target for redirects with nonzero low bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign    <= 1'b0;
            r_misalign_pc <= '0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            r_misalign    <= 1'b1;
            r_misalign_pc <= redirect_pc_i;
        end else begin
            r_misalign    <= 1'b0;
        end
    end
`endif

endmodule
